// File: rtl/stage_transition_ctrl.sv
// Stage-change sequencer: latches a door hit, fades out, swaps stage/entry X, fades in, then cools down.
// Optional macro STAGE_FADE_EN builds the fade phases; without it the sequence is IDLE -> SWAP -> COOLDOWN.
module stage_transition_ctrl #(
   parameter int unsigned FADE_STEP_FRAMES = 2,
   parameter int unsigned COOLDOWN_FRAMES  = 8,
   parameter logic [4:0]  START_STAGE      = 5'd0,
   parameter logic [31:0] START_POSX       = 32'd32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        door0_hit,
   input  logic [4:0]  door0_stage,
   input  logic [31:0] door0_posx,
   input  logic        door1_hit,
   input  logic [4:0]  door1_stage,
   input  logic [31:0] door1_posx,
   output logic [4:0]  stage_code,
   output logic        posx_load,
   output logic [31:0] posx_value,
   output logic [3:0]  fade_level,
   output logic        busy,
   output logic        freeze
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SWAP     = 3'd2;
   localparam logic [2:0] COOLDOWN = 3'd4;
`ifdef STAGE_FADE_EN
   localparam logic [2:0] FADE_OUT = 3'd1;
   localparam logic [2:0] FADE_IN  = 3'd3;
   localparam int STEP_W = (FADE_STEP_FRAMES < 2) ? 1 : $clog2(FADE_STEP_FRAMES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
`endif
   localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(COOLDOWN_FRAMES);

   logic [2:0]        state, stateNext;
   logic [COOL_W-1:0] coolCnt;
   logic [4:0]        latStage;
   logic [31:0]       latPosx;
   logic              anyHit;

   assign anyHit = door0_hit | door1_hit;

`ifdef STAGE_FADE_EN
   logic [STEP_W-1:0] stepCnt;
   logic              stepDone;
   assign stepDone = frame_tick && (stepCnt == STEP_LAST);
`else
   assign fade_level = 4'd0;
`endif

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (anyHit) begin
`ifdef STAGE_FADE_EN
            stateNext = FADE_OUT;
`else
            stateNext = SWAP;
`endif
         end
`ifdef STAGE_FADE_EN
         FADE_OUT: if (stepDone && fade_level == 4'd15) stateNext = SWAP;
         SWAP:     stateNext = FADE_IN;
         FADE_IN:  if (stepDone && fade_level == 4'd0) stateNext = COOLDOWN;
`else
         SWAP:     stateNext = COOLDOWN;
`endif
         // the player still standing in the entry door must not re-trigger
         COOLDOWN: if (coolCnt == COOL_MAX && !anyHit) stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         stage_code <= START_STAGE;
         posx_value <= START_POSX;
         posx_load  <= 1'b0;
         busy       <= 1'b0;
         freeze     <= 1'b0;
         coolCnt    <= '0;
         latStage   <= '0;
         latPosx    <= '0;
`ifdef STAGE_FADE_EN
         stepCnt    <= '0;
         fade_level <= 4'd0;
`endif
      end else begin
         state     <= stateNext;
         busy      <= (stateNext != IDLE);
         freeze    <= (stateNext != IDLE) && (stateNext != COOLDOWN);
         posx_load <= 1'b0;
         case (state)
            IDLE: if (anyHit) begin
               latStage <= door0_hit ? door0_stage : door1_stage;
               latPosx  <= door0_hit ? door0_posx  : door1_posx;
`ifdef STAGE_FADE_EN
               // a tick on the entry edge is already the first tick of FADE_OUT
               if (frame_tick) begin
                  if (STEP_LAST == '0) fade_level <= 4'd1;
                  else                 stepCnt    <= STEP_W'(1);
               end
`endif
            end
`ifdef STAGE_FADE_EN
            FADE_OUT: if (frame_tick) begin
               if (stepDone) begin
                  stepCnt <= '0;
                  if (fade_level != 4'd15) fade_level <= fade_level + 4'd1;
               end else begin
                  stepCnt <= stepCnt + STEP_W'(1);
               end
            end
            SWAP: begin
               stage_code <= latStage;
               posx_value <= latPosx;
               posx_load  <= 1'b1;
               if (frame_tick) begin
                  if (STEP_LAST == '0) fade_level <= 4'd14;
                  else                 stepCnt    <= STEP_W'(1);
               end
            end
            FADE_IN: if (frame_tick) begin
               if (stepDone) begin
                  stepCnt <= '0;
                  if (fade_level != 4'd0) fade_level <= fade_level - 4'd1;
               end else begin
                  stepCnt <= stepCnt + STEP_W'(1);
               end
            end
`else
            SWAP: begin
               stage_code <= latStage;
               posx_value <= latPosx;
               posx_load  <= 1'b1;
               coolCnt    <= frame_tick ? COOL_W'(1) : '0;
            end
`endif
            COOLDOWN: begin
               if (stateNext == IDLE)                     coolCnt <= '0;
               else if (frame_tick && coolCnt != COOL_MAX) coolCnt <= coolCnt + COOL_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_transition_ctrl.sv
// Randomized bench for stage_transition_ctrl against a tick-counting phase model.
module tb_stage_transition_ctrl;

   localparam int          FSF        = 2;
   localparam int          CF         = 8;
   localparam logic [4:0]  START_STG  = 5'd0;
   localparam logic [31:0] START_X    = 32'd32;
`ifdef STAGE_FADE_EN
   localparam bit FADE_EN = 1'b1;
`else
   localparam bit FADE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1, frame_tick = 1'b0;
   logic        door0_hit = 1'b0, door1_hit = 1'b0;
   logic [4:0]  door0_stage = '0, door1_stage = '0;
   logic [31:0] door0_posx = '0, door1_posx = '0;
   logic [4:0]  stage_code;
   logic        posx_load, busy, freeze;
   logic [31:0] posx_value;
   logic [3:0]  fade_level;

   stage_transition_ctrl #(
      .FADE_STEP_FRAMES(FSF), .COOLDOWN_FRAMES(CF), .START_STAGE(START_STG), .START_POSX(START_X)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .door0_hit(door0_hit), .door0_stage(door0_stage), .door0_posx(door0_posx),
      .door1_hit(door1_hit), .door1_stage(door1_stage), .door1_posx(door1_posx),
      .stage_code(stage_code), .posx_load(posx_load), .posx_value(posx_value),
      .fade_level(fade_level), .busy(busy), .freeze(freeze)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Model: which phase we are in and how many frame ticks that phase has seen.
   typedef enum int {P_IDLE, P_OUT, P_SWAP, P_IN, P_COOL} phase_t;
   phase_t      mPhase = P_IDLE;
   int          mTicks = 0;
   logic [4:0]  mStage = START_STG, mLatStage = '0;
   logic [31:0] mPosx = START_X, mLatPosx = '0;
   bit          mLoad = 1'b0;

   function automatic void modelStep();
      mLoad = 1'b0;
      if (reset) begin
         mPhase = P_IDLE; mTicks = 0; mStage = START_STG; mPosx = START_X;
         return;
      end
      case (mPhase)
         P_IDLE: if (door0_hit || door1_hit) begin
            mLatStage = door0_hit ? door0_stage : door1_stage;
            mLatPosx  = door0_hit ? door0_posx  : door1_posx;
            mPhase    = FADE_EN ? P_OUT : P_SWAP;
            mTicks    = (FADE_EN && frame_tick) ? 1 : 0;
         end
         P_OUT: begin
            if (frame_tick) mTicks++;
            if (mTicks == 16 * FSF) begin mPhase = P_SWAP; mTicks = 0; end
         end
         P_SWAP: begin
            mStage = mLatStage; mPosx = mLatPosx; mLoad = 1'b1;
            mPhase = FADE_EN ? P_IN : P_COOL;
            mTicks = frame_tick ? 1 : 0;
         end
         P_IN: begin
            if (frame_tick) mTicks++;
            if (mTicks == 16 * FSF) begin mPhase = P_COOL; mTicks = 0; end
         end
         default: begin
            if (mTicks >= CF && !door0_hit && !door1_hit) begin mPhase = P_IDLE; mTicks = 0; end
            else if (frame_tick && mTicks < CF) mTicks++;
         end
      endcase
   endfunction

   function automatic int expFade();
      int s;
      s = (mTicks / FSF > 15) ? 15 : mTicks / FSF;
      case (mPhase)
         P_OUT:   return s;
         P_SWAP:  return FADE_EN ? 15 : 0;
         P_IN:    return 15 - s;
         default: return 0;
      endcase
   endfunction

   task automatic cyc(input bit r, input bit h0, input bit h1, input bit t);
      reset = r; door0_hit = h0; door1_hit = h1; frame_tick = t;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      chk("stage_code", 32'(stage_code), 32'(mStage));
      chk("posx_value", posx_value, mPosx);
      chk("posx_load", 32'(posx_load), 32'(mLoad));
      chk("fade_level", 32'(fade_level), 32'(expFade()));
      chk("busy", 32'(busy), 32'(mPhase != P_IDLE));
      chk("freeze", 32'(freeze), 32'(mPhase == P_OUT || mPhase == P_SWAP || mPhase == P_IN));
   endtask

   int holdLeft;
   bit holdDoor0;

   initial begin
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 1);
      // idle with many ticks
      for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1);
      // single door1 hit, full sequence
      door1_stage = 5'd1; door1_posx = 32'd32;
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 200; i++) cyc(0, 0, 0, i % 2);
      // both doors at once: door 0 wins
      door0_stage = 5'd0; door0_posx = 32'd960; door1_stage = 5'd1; door1_posx = 32'd32;
      cyc(0, 1, 1, 1);
      for (int i = 0; i < 200; i++) cyc(0, 0, 0, i % 2);
      // door0 held through the whole sequence and deep into cooldown
      door0_stage = 5'd17; door0_posx = 32'h1234_5678;
      for (int i = 0; i < 220; i++) cyc(0, 1, 0, i % 2);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, i % 3 == 0);
      // reset in mid fade-out
      door1_stage = 5'd9; door1_posx = 32'd500;
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 200 && !(mPhase == P_OUT && expFade() == 7); i++) cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
      // randomized traffic
      holdLeft = 0; holdDoor0 = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         bit h0, h1;
         if (holdLeft == 0) begin
            door0_stage = 5'($urandom); door0_posx = $urandom;
            door1_stage = 5'($urandom); door1_posx = $urandom;
            if ($urandom_range(0, 39) == 0) begin
               holdLeft  = $urandom_range(1, 30);
               holdDoor0 = $urandom_range(0, 1) == 1;
            end
         end
         h0 = 1'b0; h1 = 1'b0;
         if (holdLeft > 0) begin
            holdLeft--;
            if (holdDoor0) h0 = 1'b1; else h1 = 1'b1;
            if ($urandom_range(0, 7) == 0) begin h0 = 1'b1; h1 = 1'b1; end
         end
         cyc($urandom_range(0, 599) == 0, h0, h1, $urandom_range(0, 2) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
